// File: rtl/brightness_ctrl.sv
// Ramps the brightness coefficient toward a written target by one step per video frame.
// Optional per-frame ramping is enabled by defining BRIGHTNESS_CTRL_RAMP_EN; otherwise each write jumps at the next frame.
module brightness_ctrl #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coe_wr_i,
  input  logic [15:0] coe_i,
  input  logic [7:0]  step_i,
  input  logic        vs_i,
  output logic [15:0] coe_o,
  output logic        busy_o,
  output logic        done_o
);
  localparam int CW = PIXEL_WIDTH + 1;
  localparam int DW = (CW + 1 > 10) ? CW + 1 : 10;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, STEP = 2'd2} state_t;

  state_t              state, state_nxt;
  logic signed [CW-1:0] target, current, cur_nxt;
  logic                vs_q, rise, hit;
  logic                unused_bits;

  assign rise        = vs_i & ~vs_q;
  assign coe_o       = 16'(current);
  assign unused_bits = ^(coe_i >> CW);

`ifdef BRIGHTNESS_CTRL_RAMP_EN
  logic [7:0]           step;
  logic signed [DW-1:0] diff, mag, stp;

  // Difference is widened so that neither |d| nor current +/- step can wrap.
  always_comb begin
    diff = DW'(target) - DW'(current);
    mag  = (diff < 0) ? -diff : diff;
    stp  = DW'({1'b0, step});
    if (step == 8'd0 || mag <= stp)
      cur_nxt = target;
    else if (diff > 0)
      cur_nxt = CW'(DW'(current) + stp);
    else
      cur_nxt = CW'(DW'(current) - stp);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      step <= '0;
    else if (coe_wr_i)
      step <= step_i;
  end
`else
  logic unused_step;
  assign unused_step = ^step_i;
  assign cur_nxt     = target;
`endif

  assign hit = (cur_nxt == target);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (coe_wr_i) state_nxt = ARMED;
      ARMED:   if (rise) state_nxt = STEP;
      // A write landing on STEP re-arms so the new target gets its own frame.
      STEP:    state_nxt = (coe_wr_i || !hit) ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      target  <= '0;
      current <= '0;
      vs_q    <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state  <= state_nxt;
      vs_q   <= vs_i;
      busy_o <= (state_nxt != IDLE);
      done_o <= (state == STEP) && !coe_wr_i && hit;
      if (state == STEP)
        current <= cur_nxt;
      if (coe_wr_i)
        target <= coe_i[CW-1:0];
    end
  end
endmodule

// File: tb/tb_brightness_ctrl.sv
// Randomized and directed checks of brightness_ctrl against a frame-level reference model.
module tb_brightness_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        coe_wr_i = 1'b0;
  logic [15:0] coe_i = '0;
  logic [7:0]  step_i = '0;
  logic        vs_i = 1'b0;
  logic [15:0] coe_o;
  logic        busy_o, done_o;

  int total = 0;
  int passed = 0;

  // Reference model: target/current as plain integers, a pending-write flag and a step-due flag.
  int   m_tgt, m_stp, m_cur;
  logic m_vsq, m_pend, m_due, m_done;

  brightness_ctrl #(.PIXEL_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .coe_wr_i(coe_wr_i), .coe_i(coe_i), .step_i(step_i),
    .vs_i(vs_i), .coe_o(coe_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic int ramp_ref(input int t, input int c, input int s);
    int d;
    d = t - c;
`ifdef BRIGHTNESS_CTRL_RAMP_EN
    if (s == 0 || (d < 0 ? -d : d) <= s) return t;
    return (d > 0) ? c + s : c - s;
`else
    return t;
`endif
  endfunction

  task automatic model_edge();
    logic       rise;
    logic [8:0] t9;
    int         nc;
    rise = vs_i && !m_vsq;
    if (!rst) begin
      m_tgt = 0; m_stp = 0; m_cur = 0;
      m_vsq = 0; m_pend = 0; m_due = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_due) begin
        nc = ramp_ref(m_tgt, m_cur, m_stp);
        m_cur = nc;
        m_due = 0;
        if (coe_wr_i) m_pend = 1;
        else if (nc == m_tgt) begin m_pend = 0; m_done = 1; end
        else m_pend = 1;
      end else if (m_pend && rise) m_due = 1;
      else if (coe_wr_i) m_pend = 1;
      if (coe_wr_i) begin
        t9 = coe_i[8:0];
        m_tgt = int'($signed(t9));
        m_stp = int'(step_i);
      end
      m_vsq = vs_i;
    end
  endtask

  task automatic tick(input logic wr, input logic [15:0] coe, input logic [7:0] stp, input logic vs);
    coe_wr_i = wr; coe_i = coe; step_i = stp; vs_i = vs;
    @(posedge clk);
    model_edge();
    #1;
    coe_wr_i = 1'b0;
  endtask

  task automatic frame();
    tick(0, 16'd0, 8'd0, 1);
    tick(0, 16'd0, 8'd0, 1);
    repeat (3) tick(0, 16'd0, 8'd0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(0, 16'd0, 8'd0, 0);
    tick(0, 16'd0, 8'd0, 0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    if ({coe_o, busy_o, done_o} !== 18'd0)
      $display("FAIL reset: got coe=%h busy=%b done=%b want 0/0/0", coe_o, busy_o, done_o);
    else passed++;
    total++;
  endtask

  task automatic test_idle_vs();
    for (int i = 0; i < 12; i++) begin
      tick(0, 16'd0, 8'd0, i[1]);
      if ({coe_o, busy_o, done_o} !== 18'd0)
        $display("FAIL idle_vs[%0d]: got coe=%h busy=%b done=%b want 0/0/0", i, coe_o, busy_o, done_o);
      else passed++;
      total++;
    end
  endtask

  task automatic test_ramp();
    logic [15:0] exp_coe[3];
    logic [15:0] prev;
    int          done_f;
`ifdef BRIGHTNESS_CTRL_RAMP_EN
    exp_coe = '{16'd16, 16'd32, 16'd40}; done_f = 2;
`else
    exp_coe = '{16'd40, 16'd40, 16'd40}; done_f = 0;
`endif
    do_reset();
    tick(1, 16'd40, 8'd16, 0);
    repeat (3) tick(0, 16'd0, 8'd0, 0);
    for (int f = 0; f < 3; f++) begin
      prev = (f == 0) ? 16'd0 : exp_coe[f-1];
      tick(0, 16'd0, 8'd0, 1);
      if (coe_o !== prev)
        $display("FAIL ramp_hold[%0d]: got coe=%h want %h", f, coe_o, prev);
      else passed++;
      total++;
      tick(0, 16'd0, 8'd0, 1);
      if ({coe_o, busy_o, done_o} !== {exp_coe[f], f < done_f, f == done_f})
        $display("FAIL ramp_step[%0d]: got coe=%h busy=%b done=%b want %h/%b/%b",
                 f, coe_o, busy_o, done_o, exp_coe[f], f < done_f, f == done_f);
      else passed++;
      total++;
      tick(0, 16'd0, 8'd0, 0);
      if (done_o !== 1'b0)
        $display("FAIL ramp_done_width[%0d]: got done=%b want 0", f, done_o);
      else passed++;
      total++;
      repeat (2) tick(0, 16'd0, 8'd0, 0);
    end
  endtask

  task automatic test_negative();
    tick(1, 16'hFFF0, 8'd0, 0);
    tick(0, 16'd0, 8'd0, 0);
    tick(0, 16'd0, 8'd0, 1);
    tick(0, 16'd0, 8'd0, 1);
    if ({coe_o, busy_o, done_o} !== {16'hFFF0, 1'b0, 1'b1})
      $display("FAIL negative: got coe=%h busy=%b done=%b want fff0/0/1", coe_o, busy_o, done_o);
    else passed++;
    total++;
  endtask

  task automatic test_retarget();
    logic [15:0] mid;
`ifdef BRIGHTNESS_CTRL_RAMP_EN
    mid = 16'd100;
`else
    mid = 16'd200;
`endif
    do_reset();
    tick(1, 16'd200, 8'd50, 0);
    tick(0, 16'd0, 8'd0, 0);
    frame();
    frame();
    if (coe_o !== mid)
      $display("FAIL retarget_mid: got coe=%h want %h", coe_o, mid);
    else passed++;
    total++;
    tick(1, 16'd60, 8'd50, 0);
    tick(0, 16'd0, 8'd0, 1);
    tick(0, 16'd0, 8'd0, 1);
    if ({coe_o, busy_o, done_o} !== {16'd60, 1'b0, 1'b1})
      $display("FAIL retarget_end: got coe=%h busy=%b done=%b want 003c/0/1", coe_o, busy_o, done_o);
    else passed++;
    total++;
  endtask

  task automatic test_coincident();
    do_reset();
    tick(1, 16'd100, 8'd10, 0);
    tick(0, 16'd0, 8'd0, 0);
    tick(1, 16'd30, 8'd0, 1);
    tick(0, 16'd0, 8'd0, 1);
    if ({coe_o, busy_o, done_o} !== {16'd30, 1'b0, 1'b1})
      $display("FAIL coincident: got coe=%h busy=%b done=%b want 001e/0/1", coe_o, busy_o, done_o);
    else passed++;
    total++;
  endtask

  task automatic test_write_in_step();
    do_reset();
    tick(1, 16'd100, 8'd0, 0);
    tick(0, 16'd0, 8'd0, 0);
    tick(0, 16'd0, 8'd0, 1);
    tick(1, 16'd20, 8'd0, 1);
    if ({coe_o, busy_o, done_o} !== {16'd100, 1'b1, 1'b0})
      $display("FAIL write_in_step: got coe=%h busy=%b done=%b want 0064/1/0", coe_o, busy_o, done_o);
    else passed++;
    total++;
    tick(0, 16'd0, 8'd0, 0);
    tick(0, 16'd0, 8'd0, 1);
    tick(0, 16'd0, 8'd0, 1);
    if ({coe_o, busy_o, done_o} !== {16'd20, 1'b0, 1'b1})
      $display("FAIL write_in_step_next: got coe=%h busy=%b done=%b want 0014/0/1", coe_o, busy_o, done_o);
    else passed++;
    total++;
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    tick(1, 16'd200, 8'd10, 0);
    tick(0, 16'd0, 8'd0, 0);
    frame();
    do_reset();
    if ({coe_o, busy_o, done_o} !== 18'd0)
      $display("FAIL reset_mid: got coe=%h busy=%b done=%b want 0/0/0", coe_o, busy_o, done_o);
    else passed++;
    total++;
    frame();
    if ({coe_o, busy_o, done_o} !== 18'd0)
      $display("FAIL reset_mid_after: got coe=%h busy=%b done=%b want 0/0/0", coe_o, busy_o, done_o);
    else passed++;
    total++;
  endtask

  task automatic test_random();
    logic [17:0] exp;
    logic        vs;
    vs = 1'b0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 3) == 0) vs = ~vs;
      tick($urandom_range(0, 9) == 0, 16'($urandom), 8'($urandom_range(0, 60)), vs);
      exp = {16'(m_cur), m_pend | m_due, m_done};
      if ({coe_o, busy_o, done_o} !== exp)
        $display("FAIL random[%0d]: got coe=%h busy=%b done=%b want %h/%b/%b",
                 i, coe_o, busy_o, done_o, exp[17:2], exp[1], exp[0]);
      else passed++;
      total++;
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_idle_vs();
    test_ramp();
    test_negative();
    test_retarget();
    test_coincident();
    test_write_in_step();
    test_reset_mid_ramp();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/brightness_ctrl.md
BRIGHTNESS_CTRL -- requirements
Module: brightness_ctrl

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8: pixel width of the controlled brightness filter; the coefficient is CW = PIXEL_WIDTH+1 bits, two's complement.
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 coe_wr_i  input  1  one-cycle strobe; loads a new target coefficient.
REQ-005 coe_i  input  16  new target; bits [CW-1:0] used, upper bits ignored.
REQ-006 step_i  input  8  unsigned ramp step per frame, sampled with coe_wr_i; 0 means jump directly.
REQ-007 vs_i  input  1  vertical sync of the video stream feeding the filter; rising edge marks a frame boundary.
REQ-008 coe_o  output  16  coefficient to the brightness filter: [CW-1:0] current value, sign-extended to 16 bits.
REQ-009 busy_o  output  1  high whenever the state is not IDLE.
REQ-010 done_o  output  1  one-cycle pulse when coe_o reaches the target.

Function
REQ-011 The block SHALL hold registers: target (CW), step (8), current (CW), vs_q (1), and a state machine IDLE / ARMED / STEP.
REQ-012 Frame edge rise SHALL be vs_i & ~vs_q, where vs_q is vs_i delayed one clk.
REQ-013 coe_o SHALL change only in the cycle after STEP, never at any other time.
REQ-014 On coe_wr_i in any state, target <= coe_i[CW-1:0], step <= step_i, and the state SHALL go to ARMED; current is not modified.
REQ-015 If the written target equals current, the state SHALL still go to ARMED; the next rise then produces STEP, done_o, and a return to IDLE.
REQ-016 ARMED -> STEP on rise; otherwise stay.
REQ-017 In STEP, with d = target - current computed at CW+1 bits signed:
- d = 0, or step = 0, or |d| <= step: current <= target.
- Otherwise: current <= current + step when d > 0, and current - step when d < 0.
REQ-018 No intermediate value SHALL leave the CW signed range; no overshoot past target.
REQ-019 STEP SHALL last exactly one cycle, then:
- If the new current equals target: go to IDLE and pulse done_o in that same cycle.
- Otherwise: go to ARMED.
REQ-020 Timing: vs_i is first sampled high at cycle N (low at N-1) while ARMED. The state is STEP at N+1, and coe_o shows the new value at N+2.
REQ-021 coe_wr_i and rise in the same cycle while ARMED:
- target and step update.
- The transition to STEP still occurs.
- STEP uses the new target and step.
REQ-022 coe_wr_i during STEP: the STEP result uses the old target, and the state then goes to ARMED regardless of equality. done_o SHALL NOT pulse in that cycle.
REQ-023 rise while IDLE SHALL be ignored.
REQ-024 busy_o and done_o SHALL be registered outputs.

Reset
REQ-025 While rst = 0 at a clk edge, the block SHALL set:
- state = IDLE
- target = 0, current = 0, step = 0
- vs_q = 0
- coe_o = 0, busy_o = 0, done_o = 0
REQ-026 Reset mid-ramp SHALL abandon the ramp; after reset the first action is a fresh coe_wr_i.

Configuration
REQ-027 Macro BRIGHTNESS_CTRL_RAMP_EN, when defined: ramping is per REQ-017.
REQ-028 When undefined:
- step_i SHALL be ignored and the step register omitted.
- Every STEP SHALL load current <= target, so each write completes at the first rise.
- All timing otherwise unchanged.

Verification
REQ-029 Reset then idle vs_i toggling -> coe_o = 0, busy_o = 0, done_o never pulses.
REQ-030 PIXEL_WIDTH = 8, RAMP_EN defined, write coe_i = 40, step_i = 16, then 3 vs rises -> coe_o takes 16, 32, 40, each 2 cycles after rise; done_o pulses with the third STEP; busy_o falls on the same edge.
REQ-031 From current 40, write coe_i = 16'hFFF0 (-16), step 0 -> coe_o = 16'hFFF0 after the first rise, with done_o pulse.
REQ-032 Ramp from 0 toward 200, step 50; write target 60 after the second frame (current 100) -> next rise gives 60 and done_o.
REQ-033 Write coincident with rise; write during STEP; rst asserted mid-ramp -> behaviour per REQ-021, REQ-022 and REQ-025 respectively.
REQ-034 RAMP_EN undefined, write coe_i = 255, step 4 -> coe_o = 255 after the first rise.
